// File: rtl/conv_encoder_k3_tx.sv
// Rate-1/2, K=3 convolutional encoder: one MSG_W-bit block in, MSB first, streamed out as 2-bit symbols
// with valid/ready; the packed codeword (first symbol on top) is published at block end.
module conv_encoder_k3_tx #(
    parameter int unsigned MSG_W = 8,
    parameter logic [2:0]  G0    = 3'b111,
    parameter logic [2:0]  G1    = 3'b101,
    parameter int unsigned TAIL  = 0,
    localparam int unsigned NSYM = MSG_W + 2 * TAIL,
    localparam int unsigned CW_W = 2 * NSYM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_first,
    output logic             sym_last,
    output logic [CW_W-1:0]  code_word,
    output logic             code_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(NSYM + 1);
    localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(MSG_W - 1);
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(NSYM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         s_q, s_d;
    logic [MSG_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW_W-1:0]    stage_q, stage_d;
    logic [1:0]         sym_out_q, sym_out_d;
    logic               sym_valid_q, sym_valid_d;
    logic               sym_first_q, sym_first_d;
    logic               sym_last_q, sym_last_d;
    logic [CW_W-1:0]    code_word_q, code_word_d;
    logic               code_valid_q, code_valid_d;

    logic               xfer_c;
    logic               u_c;
    logic [1:0]         s_adv_c;
    logic [MSG_W-1:0]   buf_adv_c;
    logic [CNT_W-1:0]   cnt_adv_c;
    logic [CW_W-1:0]    stage_adv_c;

    // Symbol {c0,c1} for input bit u entering shift state s.
    function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] s);
        logic [2:0] w;
        w = {u, s};
        return {^(w & G0), ^(w & G1)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s_q          <= 2'b00;
            buf_q        <= '0;
            cnt_q        <= '0;
            stage_q      <= '0;
            sym_out_q    <= 2'b00;
            sym_valid_q  <= 1'b0;
            sym_first_q  <= 1'b0;
            sym_last_q   <= 1'b0;
            code_word_q  <= '0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            sym_out_q    <= sym_out_d;
            sym_valid_q  <= sym_valid_d;
            sym_first_q  <= sym_first_d;
            sym_last_q   <= sym_last_d;
            code_word_q  <= code_word_d;
            code_valid_q <= code_valid_d;
        end
    end

    // The registered symbol always belongs to the bit at the buffer MSB; a transfer
    // advances the trellis and preloads the following symbol.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        sym_out_d    = sym_out_q;
        sym_valid_d  = sym_valid_q;
        sym_first_d  = sym_first_q;
        sym_last_d   = sym_last_q;
        code_word_d  = code_word_q;
        code_valid_d = 1'b0;

        xfer_c      = sym_valid_q && sym_ready;
        u_c         = (state_q == FLUSH) ? 1'b0 : buf_q[MSG_W-1];
        s_adv_c     = {u_c, s_q[1]};
        buf_adv_c   = {buf_q[MSG_W-2:0], 1'b0};
        cnt_adv_c   = cnt_q + CNT_W'(1);
        stage_adv_c = {stage_q[CW_W-3:0], sym_out_q};

        case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    state_d     = ENCODE;
                    buf_d       = msg_in;
                    s_d         = 2'b00;
                    cnt_d       = '0;
                    sym_out_d   = enc_sym(msg_in[MSG_W-1], 2'b00);
                    sym_valid_d = 1'b1;
                    sym_first_d = 1'b1;
                    sym_last_d  = 1'b0;
                end
            end
            ENCODE, FLUSH: begin
                if (xfer_c) begin
                    s_d         = s_adv_c;
                    buf_d       = buf_adv_c;
                    cnt_d       = cnt_adv_c;
                    stage_d     = stage_adv_c;
                    sym_first_d = 1'b0;
                    if ((state_q == ENCODE && cnt_q == LAST_MSG && TAIL != 0)) begin
                        state_d    = FLUSH;
                        sym_out_d  = enc_sym(1'b0, s_adv_c);
                        sym_last_d = 1'b0;
                    end else if (cnt_q == LAST_SYM) begin
                        state_d      = DONE;
                        sym_valid_d  = 1'b0;
                        sym_last_d   = 1'b0;
                        code_word_d  = stage_adv_c;
                        code_valid_d = 1'b1;
                    end else begin
                        sym_out_d  = enc_sym((state_q == FLUSH) ? 1'b0 : buf_adv_c[MSG_W-1], s_adv_c);
                        sym_last_d = (cnt_adv_c == LAST_SYM);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign msg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sym_out    = sym_out_q;
    assign sym_valid  = sym_valid_q;
    assign sym_first  = sym_first_q;
    assign sym_last   = sym_last_q;
    assign code_word  = code_word_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_conv_encoder_k3_tx.sv
// Directed bench for conv_encoder_k3_tx: one untailed and one tailed instance, hand-computed codewords.
module tb_conv_encoder_k3_tx;

    logic        clk;
    logic        rst;

    logic [7:0]  msg_in;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_first;
    logic        sym_last;
    logic [15:0] code_word;
    logic        code_valid;
    logic        busy;

    logic [7:0]  t_msg_in;
    logic        t_msg_valid;
    logic        t_msg_ready;
    logic [1:0]  t_sym_out;
    logic        t_sym_valid;
    logic        t_sym_ready;
    logic        t_sym_first;
    logic        t_sym_last;
    logic [19:0] t_code_word;
    logic        t_code_valid;
    logic        t_busy;

    int total;
    int bad;

    conv_encoder_k3_tx #(.MSG_W(8), .G0(3'b111), .G1(3'b101), .TAIL(0)) u_dut (
        .clk(clk), .rst(rst),
        .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_first(sym_first), .sym_last(sym_last),
        .code_word(code_word), .code_valid(code_valid), .busy(busy)
    );

    conv_encoder_k3_tx #(.MSG_W(8), .G0(3'b111), .G1(3'b101), .TAIL(1)) u_dut_tail (
        .clk(clk), .rst(rst),
        .msg_in(t_msg_in), .msg_valid(t_msg_valid), .msg_ready(t_msg_ready),
        .sym_out(t_sym_out), .sym_valid(t_sym_valid), .sym_ready(t_sym_ready),
        .sym_first(t_sym_first), .sym_last(t_sym_last),
        .code_word(t_code_word), .code_valid(t_code_valid), .busy(t_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One block on the untailed encoder; the expected symbol stream is the codeword itself.
    task automatic run_blk(input logic [7:0] msg, input logic [15:0] cw, input bit bp, input bit noise);
        int         k;
        int         cyc;
        bit         rdy;
        bit         xfer;
        logic [1:0] es;
        @(negedge clk);
        chk("accept_ready", 32'(msg_ready), 32'd1);
        msg_in    = msg;
        msg_valid = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_in    = 8'h00;
        chk("busy", 32'(busy), 32'd1);
        chk("ready_low", 32'(msg_ready), 32'd0);
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            es = cw[15-2*k -: 2];
            chk("cv_early", 32'(code_valid), 32'd0);
            chk("sym_valid", 32'(sym_valid), 32'd1);
            chk("sym", 32'(sym_out), 32'(es));
            chk("first", 32'(sym_first), 32'(k == 0));
            chk("last", 32'(sym_last), 32'(k == 7));
            rdy = bp ? (cyc % 3 == 0) : 1'b1;
            if (noise) begin
                msg_valid = (cyc == 2);
                msg_in    = 8'h00;
            end
            sym_ready = rdy;
            xfer      = sym_valid && rdy;
            @(negedge clk);
            cyc++;
            if (xfer) k++;
        end
        msg_valid = 1'b0;
        sym_ready = 1'b1;
        chk("sym_count", 32'(k), 32'd8);
        if (!bp) chk("latency", 32'(cyc), 32'd8);
        chk("cv_pulse", 32'(code_valid), 32'd1);
        chk("code_word", 32'(code_word), 32'(cw));
        chk("valid_off", 32'(sym_valid), 32'd0);
        @(negedge clk);
        chk("cv_drop", 32'(code_valid), 32'd0);
        chk("idle_ready", 32'(msg_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("cw_hold", 32'(code_word), 32'(cw));
    endtask

    task automatic run_tail();
        logic [19:0] tcw;
        logic [1:0]  es;
        int          k;
        int          cyc;
        bit          xfer;
        tcw = 20'hEC000;
        @(negedge clk);
        t_msg_in    = 8'h80;
        t_msg_valid = 1'b1;
        @(negedge clk);
        t_msg_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 10 && cyc < 100) begin
            es = tcw[19-2*k -: 2];
            chk("t_sym_valid", 32'(t_sym_valid), 32'd1);
            chk("t_sym", 32'(t_sym_out), 32'(es));
            chk("t_first", 32'(t_sym_first), 32'(k == 0));
            chk("t_last", 32'(t_sym_last), 32'(k == 9));
            xfer = t_sym_valid;
            @(negedge clk);
            cyc++;
            if (xfer) k++;
        end
        chk("t_sym_count", 32'(k), 32'd10);
        chk("t_latency", 32'(cyc), 32'd10);
        chk("t_cv_pulse", 32'(t_code_valid), 32'd1);
        chk("t_code_word", 32'(t_code_word), 32'(tcw));
        @(negedge clk);
        chk("t_cv_drop", 32'(t_code_valid), 32'd0);
        chk("t_idle", 32'(t_msg_ready), 32'd1);
    endtask

    task automatic run_reset_abort();
        @(negedge clk);
        msg_in    = 8'hB0;
        msg_valid = 1'b1;
        sym_ready = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_sym", 32'(sym_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_sym", 32'(sym_out), 32'd0);
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(msg_ready), 32'd1);
        chk("rst_cw", 32'(code_word), 32'd0);
        chk("rst_cv", 32'(code_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_cv", 32'(code_valid), 32'd0);
            chk("abort_valid", 32'(sym_valid), 32'd0);
        end
        chk("abort_cw", 32'(code_word), 32'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        msg_in      = 8'h00;
        msg_valid   = 1'b0;
        sym_ready   = 1'b1;
        t_msg_in    = 8'h00;
        t_msg_valid = 1'b0;
        t_sym_ready = 1'b1;
        #1;
        chk("reset_valid", 32'(sym_valid), 32'd0);
        chk("reset_sym", 32'(sym_out), 32'd0);
        chk("reset_ready", 32'(msg_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cw", 32'(code_word), 32'd0);
        chk("reset_cv", 32'(code_valid), 32'd0);
        chk("reset_t_cw", 32'(t_code_word), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_blk(8'h80, 16'hEC00, 1'b0, 1'b0);
        run_blk(8'hB0, 16'hE170, 1'b0, 1'b0);
        run_blk(8'hFF, 16'hDAAA, 1'b0, 1'b1);
        run_blk(8'h80, 16'hEC00, 1'b0, 1'b0);
        run_blk(8'hB0, 16'hE170, 1'b1, 1'b0);
        run_tail();
        run_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
